// File: rtl/pattern_sweep_gen.sv
// Valid/ready stimulus source sweeping IN_W-bit vectors in counter or Galois-LFSR order.
// Optional response signature (MISR) enabled by defining PATTERN_SWEEP_MISR_EN.
module pattern_sweep_gen #(
  parameter int              IN_W      = 11,
  parameter int              OUT_W     = 16,
  parameter logic [IN_W-1:0] LFSR_POLY = 11'h500,
  parameter logic [IN_W-1:0] SEED      = 11'h001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [IN_W:0]    num_vec,
  output logic [IN_W-1:0]  vec_data,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [IN_W:0]    vec_idx,
  output logic             busy,
`ifdef PATTERN_SWEEP_MISR_EN
  input  logic [OUT_W-1:0] resp_data,
  input  logic             resp_valid,
  output logic [OUT_W-1:0] signature,
`endif
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IN_W-1:0] VEC_ZERO = {IN_W{1'b0}};
  localparam logic [IN_W-1:0] VEC_ONE  = {{(IN_W-1){1'b0}}, 1'b1};
  localparam logic [IN_W:0]   CNT_ZERO = {(IN_W+1){1'b0}};
  localparam logic [IN_W:0]   CNT_ONE  = {{IN_W{1'b0}}, 1'b1};
  // Full-space counts: every code for the counter, every nonzero code for the LFSR.
  localparam logic [IN_W:0]   CNT_FULL  = {1'b1, {IN_W{1'b0}}};
  localparam logic [IN_W:0]   LFSR_FULL = {1'b0, {IN_W{1'b1}}};
  localparam logic [IN_W-1:0] SEED_EFF  = (SEED == VEC_ZERO) ? VEC_ONE : SEED;

  state_t          state_r;
  logic            mode_r;
  logic [IN_W:0]   remaining_r;

  function automatic logic [IN_W-1:0] lfsr_next(input logic [IN_W-1:0] s);
    lfsr_next = (s >> 1) ^ (s[0] ? LFSR_POLY : VEC_ZERO);
  endfunction

  // Sweep FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      mode_r      <= 1'b0;
      remaining_r <= CNT_ZERO;
      vec_data    <= VEC_ZERO;
      vec_valid   <= 1'b0;
      vec_idx     <= CNT_ZERO;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_r <= mode;
            if (num_vec == CNT_ZERO) begin
              remaining_r <= mode ? LFSR_FULL : CNT_FULL;
            end else begin
              remaining_r <= num_vec;
            end
            vec_data  <= mode ? SEED_EFF : VEC_ZERO;
            vec_idx   <= CNT_ZERO;
            vec_valid <= 1'b1;
            busy      <= 1'b1;
            state_r   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (vec_ready) begin
            remaining_r <= remaining_r - CNT_ONE;
            // Final transfer: leave data/index on the last vector, no wrap.
            if (remaining_r == CNT_ONE) begin
              vec_valid <= 1'b0;
              done      <= 1'b1;
              state_r   <= ST_DONE;
            end else begin
              vec_data <= mode_r ? lfsr_next(vec_data) : (vec_data + VEC_ONE);
              vec_idx  <= vec_idx + CNT_ONE;
            end
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          vec_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

`ifdef PATTERN_SWEEP_MISR_EN
  localparam logic [OUT_W-1:0] MISR_POLY = 16'h1021;
  localparam logic [OUT_W-1:0] SIG_ZERO  = {OUT_W{1'b0}};

  function automatic logic [OUT_W-1:0] misr_next(input logic [OUT_W-1:0] sig,
                                                  input logic [OUT_W-1:0] resp);
    misr_next = ((sig << 1) ^ (sig[OUT_W-1] ? MISR_POLY : SIG_ZERO)) ^ resp;
  endfunction

  // Response signature: cleared by an accepted start, compacts responses while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      signature <= SIG_ZERO;
    end else if (state_r == ST_IDLE) begin
      if (start) begin
        signature <= SIG_ZERO;
      end
    end else if (resp_valid) begin
      signature <= misr_next(signature, resp_data);
    end
  end
`endif

endmodule

// File: tb/tb_pattern_sweep_gen.sv
// Scoreboard bench for pattern_sweep_gen: expected vectors are queued at start and
// popped on each transfer; MISR checks compile only with PATTERN_SWEEP_MISR_EN.
module tb_pattern_sweep_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mode;
  logic [11:0] num_vec;
  logic [10:0] vec_data;
  logic        vec_valid;
  logic        vec_ready;
  logic [11:0] vec_idx;
  logic        busy;
  logic        done;
`ifdef PATTERN_SWEEP_MISR_EN
  logic [15:0] resp_data;
  logic        resp_valid;
  logic [15:0] signature;
`endif

  int checks;
  int failures;

  typedef struct {
    logic [10:0] data;
    logic [11:0] idx;
  } exp_t;

  exp_t q[$];

  pattern_sweep_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .num_vec   (num_vec),
    .vec_data  (vec_data),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_idx   (vec_idx),
    .busy      (busy),
`ifdef PATTERN_SWEEP_MISR_EN
    .resp_data (resp_data),
    .resp_valid(resp_valid),
    .signature (signature),
`endif
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] lfsr_model(input logic [10:0] s);
    lfsr_model = (s >> 1) ^ (s[0] ? 11'h500 : 11'h000);
  endfunction

  task automatic fill_model(input logic m, input logic [11:0] n);
    int cnt;
    logic [10:0] s;
    q.delete();
    cnt = (n == 12'd0) ? (m ? 2047 : 2048) : int'(n);
    s = m ? 11'h001 : 11'h000;
    for (int i = 0; i < cnt; i++) begin
      q.push_back('{s, 12'(i)});
      s = m ? lfsr_model(s) : (s + 11'd1);
    end
  endtask

  // Runs one sweep against the queued expectations; stall/ignored-start/reset hooks by index.
  task automatic sweep(input logic m, input logic [11:0] n, input int stall_idx,
                       input int ign_idx, input int rst_idx, input int budget);
    int   cyc, stalled, last_xfer, done_cyc, bad;
    bit   fin;
    logic seen [0:2047];
    exp_t e;
    for (int i = 0; i < 2048; i++) seen[i] = 1'b0;
    cyc = 0; stalled = 0; last_xfer = -10; done_cyc = -1; bad = 0; fin = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = m; num_vec = n; vec_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = ~m; num_vec = 12'd3;
    chk("valid_latency", 32'(vec_valid), 32'd1);
    chk("busy_on", 32'(busy), 32'd1);
    while (!fin && cyc < budget) begin
      start = 1'b0;
      if (rst_idx >= 0 && vec_valid && int'(vec_idx) == rst_idx) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", 32'(vec_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(vec_data), 32'd0);
        chk("rst_idx", 32'(vec_idx), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        q.delete();
        fin = 1'b1;
      end else if (done) begin
        done_cyc = cyc;
        fin = 1'b1;
      end else begin
        if (vec_valid && int'(vec_idx) == stall_idx && stalled < 3) begin
          vec_ready = 1'b0;
          stalled++;
        end else begin
          vec_ready = 1'b1;
        end
        if (vec_valid && int'(vec_idx) == ign_idx) begin
          start = 1'b1; mode = 1'b1; num_vec = 12'd2;
        end
        if (vec_valid) begin
          if (q.size() == 0) begin
            chk("extra_vector", 32'(vec_valid), 32'd0);
          end else begin
            e = q[0];
            chk("vec_data", 32'(vec_data), 32'(e.data));
            chk("vec_idx", 32'(vec_idx), 32'(e.idx));
            if (vec_ready) begin
              void'(q.pop_front());
              last_xfer = cyc;
              if (vec_data == 11'd0 || seen[vec_data]) bad++;
              seen[vec_data] = 1'b1;
            end
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    vec_ready = 1'b1;
    chk("sweep_finished", 32'(fin), 32'd1);
    if (done_cyc >= 0) begin
      chk("done_timing", 32'(done_cyc), 32'(last_xfer + 1));
      chk("busy_in_done", 32'(busy), 32'd1);
      chk("valid_in_done", 32'(vec_valid), 32'd0);
      chk("sb_drained", 32'(q.size()), 32'd0);
      if (m) chk("lfsr_dup_or_zero", 32'(bad), 32'd0);
      if (stall_idx >= 0) chk("stall_cycles", 32'(stalled), 32'd3);
      @(negedge clk);
      chk("done_single", 32'(done), 32'd0);
      chk("busy_off", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; start = 1'b0; mode = 1'b0; num_vec = 12'd0; vec_ready = 1'b1;
`ifdef PATTERN_SWEEP_MISR_EN
    resp_data = 16'h0000; resp_valid = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_data", 32'(vec_data), 32'd0);
    chk("reset_valid", 32'(vec_valid), 32'd0);
    chk("reset_idx", 32'(vec_idx), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);

    // Counter, 4 vectors.
    fill_model(1'b0, 12'd4);
    sweep(1'b0, 12'd4, -1, -1, -1, 50);
    chk("cnt4_last_data", 32'(vec_data), 32'd3);

    // LFSR, 4 vectors against literal expectations.
    q.delete();
    q.push_back('{11'h001, 12'd0});
    q.push_back('{11'h500, 12'd1});
    q.push_back('{11'h280, 12'd2});
    q.push_back('{11'h140, 12'd3});
    sweep(1'b1, 12'd4, -1, -1, -1, 50);

    // Backpressure: hold at index 2 for three cycles.
    fill_model(1'b0, 12'd8);
    sweep(1'b0, 12'd8, 2, -1, -1, 50);
    chk("bp_last_data", 32'(vec_data), 32'd7);

    // Full LFSR period.
    fill_model(1'b1, 12'd0);
    sweep(1'b1, 12'd0, -1, -1, -1, 3000);
    chk("lfsr_full_last_idx", 32'(vec_idx), 32'd2046);

    // Full counter space, no wrap.
    fill_model(1'b0, 12'd0);
    sweep(1'b0, 12'd0, -1, -1, -1, 3000);
    chk("cnt_full_last_data", 32'(vec_data), 32'h7FF);
    chk("cnt_full_last_idx", 32'(vec_idx), 32'd2047);

    // Start while busy is ignored; reset at index 5.
    fill_model(1'b0, 12'd16);
    sweep(1'b0, 12'd16, -1, 2, 5, 50);
    fill_model(1'b0, 12'd4);
    sweep(1'b0, 12'd4, -1, -1, -1, 50);

`ifdef PATTERN_SWEEP_MISR_EN
    vec_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; num_vec = 12'd2;
    @(negedge clk);
    start = 1'b0;
    chk("misr_start_clear", 32'(signature), 32'h0000);
    resp_valid = 1'b1; resp_data = 16'h0001;
    @(negedge clk);
    chk("misr_first", 32'(signature), 32'h0001);
    resp_data = 16'h0000;
    @(negedge clk);
    chk("misr_shift", 32'(signature), 32'h0002);
    repeat (14) @(negedge clk);
    chk("misr_msb", 32'(signature), 32'h8000);
    resp_data = 16'h8000;
    @(negedge clk);
    chk("misr_feedback", 32'(signature), 32'h9021);
    resp_valid = 1'b0; vec_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("misr_busy_off", 32'(busy), 32'd0);
    chk("misr_hold", 32'(signature), 32'h9021);
    resp_valid = 1'b1; resp_data = 16'h00FF;
    @(negedge clk);
    chk("misr_idle_ignored", 32'(signature), 32'h9021);
    resp_valid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("misr_restart_clear", 32'(signature), 32'h0000);
    repeat (4) @(negedge clk);
    chk("misr_sweep_end", 32'(busy), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
